// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache block fill logic.
package cache_pkg;

  // 16-bit words per cache block (16-byte blocks)
  localparam int BLOCK_WORDS = 8;

  // Width of the word counters; must be able to hold the value BLOCK_WORDS
  localparam int CNT_W = 4;

  // Clears the byte offset within a block to give the block base address
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  // Fill sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: counts 0..BLOCK_WORDS and then holds,
// raising done_o once all words of the block have been counted.
module fill_counter
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == CNT_W'(BLOCK_WORDS));
  assign cnt_o  = cnt_q;

  // Clear has priority; increments saturate at the terminal count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill sequencer. On a miss it streams BLOCK_WORDS read
// requests to main memory while independently writing returned words into
// the data array, then writes the tag for one cycle.
//
// Memory interface: no valid/ready handshake. mem_enable is a one-cycle
// request that memory always accepts; memory_data_valid marks one returned
// word per cycle, in request order, with any latency. Returned words are
// counted, not matched to request timing.
//
// The counters hold 0..8 and the in-block offset is bits [3:1], so the
// BLOCK_WORDS parameter must stay at 8.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] write_addr,
  output logic [15:0]       write_data,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] tag_addr,
  output logic              fsm_busy,
  output logic [1:0]        dbg_state
);

  fill_state_e       state_q;
  logic [ADDR_W-1:0] base_q;

  logic             accept;
  logic             issue_en;
  logic             wr_en;
  logic             last_wr;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic             issue_done;
  logic             recv_done;

  assign accept   = (state_q == IDLE) && miss_detected;
  assign issue_en = (state_q == FILL) && !issue_done;
  assign wr_en    = (state_q == FILL) && memory_data_valid && !recv_done;
  assign last_wr  = wr_en && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

  fill_counter u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .inc_i  (issue_en),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  fill_counter u_recv_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .inc_i  (wr_en),
    .cnt_o  (recv_cnt),
    .done_o (recv_done)
  );

  // State and block base: base only loads on an accepted miss from IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q  <= miss_address & ADDR_W'(BLOCK_MASK);
            state_q <= FILL;
          end
        end
        FILL: begin
          if (last_wr) begin
            state_q <= TAG;
          end
        end
        TAG:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Base low nibble is zero and offsets stay <= 14, so the add never
  // carries out of the block.
  assign mem_enable       = issue_en;
  assign memory_address   = issue_en ? (base_q + ADDR_W'({issue_cnt, 1'b0})) : '0;
  assign write_data_array = wr_en;
  assign write_addr       = wr_en ? (base_q + ADDR_W'({recv_cnt, 1'b0})) : '0;
  assign write_data       = rst_n ? memory_data : '0;
  assign write_tag_array  = (state_q == TAG);
  assign tag_addr         = (state_q == TAG) ? base_q : '0;
  assign fsm_busy         = rst_n && ((state_q != IDLE) || miss_detected);
  assign dbg_state        = state_q;

endmodule
